// File: rtl/alu_pkg.sv
// Shared types for the shifter result path: occupancy state and the stored entry.
package alu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic             z;
    logic             n;
    logic             c;
    logic             r;
  } entry_t;

endpackage

// File: rtl/shift_flag_calc.sv
// Combinational flag derivation and consistency check for one shifter result.
module shift_flag_calc
  import alu_pkg::*;
#(
  parameter int N = ALU_W
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] shift,
  input  logic [N-1:0] y,
  output entry_t       entry,
  output logic         mismatch
);

  logic [N-1:0] expected;
  logic         carry;

  always_comb begin
    // Shifting by N or more leaves nothing, so the expected value is 0 there.
    expected = a << shift;
    carry    = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (32'(shift) == 32'(i)) carry = a[N-i];
    end
  end

  assign entry.result = y;
  assign entry.z      = (y == '0);
  assign entry.n      = y[N-1];
  assign entry.c      = carry;
  assign entry.r      = (32'(shift) >= 32'(N));
  assign mismatch     = (y != expected);

endmodule

// File: rtl/shift_result_stage.sv
// Registered output stage for the left shifter: 2-entry skid buffer with flags
// and a sticky consistency-error bit.
module shift_result_stage
  import alu_pkg::*;
#(
  parameter int N = ALU_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] shift,
  input  logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         flag_z,
  output logic         flag_n,
  output logic         flag_c,
  output logic         flag_r,
  output logic         err_sticky,
  output logic [1:0]   dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready on that
  // side; valid never waits on ready, and in_ready is a register that does not
  // look at out_ready in the same cycle.
  occ_state_t state;
  entry_t     m_q, s_q, new_entry;
  logic       mismatch;
  logic       in_xfer, out_xfer;

  shift_flag_calc #(.N(N)) u_calc (
    .a        (a),
    .shift    (shift),
    .y        (y),
    .entry    (new_entry),
    .mismatch (mismatch)
  );

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (in_xfer && mismatch) err_sticky <= 1'b1;
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            m_q       <= new_entry;
            state     <= ST_ONE;
            out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            m_q <= new_entry;
          end else if (in_xfer) begin
            s_q      <= new_entry;
            state    <= ST_FULL;
            in_ready <= 1'b0;
          end else if (out_xfer) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a drain can happen.
          if (out_xfer) begin
            m_q      <= s_q;
            state    <= ST_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign result    = m_q.result;
  assign flag_z    = m_q.z;
  assign flag_n    = m_q.n;
  assign flag_c    = m_q.c;
  assign flag_r    = m_q.r;
  assign dbg_state = state;

endmodule

// File: tb/tb_shift_result_stage.sv
// Bench for shift_result_stage: flag vector table, directed handshake sequences,
// and a randomized run against an occupancy/queue reference model.
module tb_shift_result_stage;
  import alu_pkg::*;

  localparam int N = 4;

  logic         clk, reset;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0] a, shift, y, result;
  logic         flag_z, flag_n, flag_c, flag_r, err_sticky;
  logic [1:0]   dbg_state;

  int checks = 0;
  int passes = 0;

  shift_result_stage #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .shift      (shift),
    .y          (y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_c     (flag_c),
    .flag_r     (flag_r),
    .err_sticky (err_sticky),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  function automatic logic [7:0] dut_word();
    return {result, flag_z, flag_n, flag_c, flag_r};
  endfunction

  // Reference: arithmetic form of the rules, independent of RTL structure.
  function automatic logic [7:0] model_word(input int av, input int sv, input int yv);
    int exp_c, exp_r;
    exp_r = (sv >= N) ? 1 : 0;
    exp_c = (sv >= 1 && sv <= N) ? ((av / (2 ** (N - sv))) % 2) : 0;
    return {4'(yv), 1'(yv == 0), 1'(yv >= 8), 1'(exp_c), 1'(exp_r)};
  endfunction

  function automatic int model_shifted(input int av, input int sv);
    return (sv >= N) ? 0 : ((av * (2 ** sv)) % (2 ** N));
  endfunction

  task automatic drive(input logic v, input int av, input int sv, input int yv);
    in_valid = v;
    a        = 4'(av);
    shift    = 4'(sv);
    y        = 4'(yv);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int a_v, s_v, y_v;
    logic [3:0] res;
    logic z, n, c, r;
  } vec_t;

  vec_t vecs[7];
  logic [7:0] exp_q[$];

  initial begin
    logic       model_err;
    logic       iv, orr, exp_ready, exp_valid;
    int         av, sv, yv;

    vecs[0] = '{1, 1, 2, 4'b0010, 0, 0, 0, 0};
    vecs[1] = '{9, 1, 2, 4'b0010, 0, 0, 1, 0};
    vecs[2] = '{15, 2, 12, 4'b1100, 0, 1, 1, 0};
    vecs[3] = '{8, 1, 0, 4'b0000, 1, 0, 1, 0};
    vecs[4] = '{15, 4, 0, 4'b0000, 1, 0, 1, 1};
    vecs[5] = '{5, 0, 5, 4'b0101, 0, 0, 0, 0};
    vecs[6] = '{6, 15, 0, 4'b0000, 1, 0, 0, 1};

    // reset state
    reset = 1'b1;
    drive(1'b0, 0, 0, 0);
    out_ready = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_word", 32'(dut_word()), 0);
    chk("reset_err", 32'(err_sticky), 0);
    chk("reset_state", 32'(dbg_state), 32'(ST_EMPTY));
    @(negedge clk);
    reset = 1'b0;

    // flag vector table, one entry at a time with out_ready high
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vecs[i].a_v, vecs[i].s_v, vecs[i].y_v);
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d_word", i), 32'(dut_word()),
          32'({vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].r}));
      chk($sformatf("vec%0d_err", i), 32'(err_sticky), 0);
      @(negedge clk);
    end
    chk("drained_valid", 32'(out_valid), 0);

    // backpressure and simultaneous transfer in ONE
    out_ready = 1'b0;
    drive(1'b1, 1, 1, 2);
    @(negedge clk);
    chk("bp_ready1", 32'(in_ready), 1);
    drive(1'b1, 1, 2, 4);
    @(negedge clk);
    chk("bp_ready_full", 32'(in_ready), 0);
    chk("bp_state_full", 32'(dbg_state), 32'(ST_FULL));
    chk("bp_head", 32'(result), 2);
    drive(1'b1, 1, 3, 8);
    @(negedge clk);
    chk("bp_still_full", 32'(in_ready), 0);
    chk("bp_hold", 32'(result), 2);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second", 32'(result), 4);
    chk("bp_ready_back", 32'(in_ready), 1);
    chk("bp_state_one", 32'(dbg_state), 32'(ST_ONE));
    @(negedge clk);
    in_valid = 1'b0;
    chk("simul_state_one", 32'(dbg_state), 32'(ST_ONE));
    chk("simul_third", 32'(result), 8);
    chk("simul_valid", 32'(out_valid), 1);
    @(negedge clk);
    chk("bp_empty", 32'(out_valid), 0);

    // mismatch detection, sticky across good entries
    drive(1'b1, 3, 1, 7);
    @(negedge clk);
    chk("mm_err_set", 32'(err_sticky), 1);
    drive(1'b1, 3, 1, 6);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mm_err_stays", 32'(err_sticky), 1);
    @(negedge clk);

    // reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 1, 0, 1);
    @(negedge clk);
    drive(1'b1, 2, 0, 2);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_pre_full", 32'(dbg_state), 32'(ST_FULL));
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_ready", 32'(in_ready), 1);
    chk("rst_mid_err", 32'(err_sticky), 0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_no_ghost", 32'(out_valid), 0);
    @(negedge clk);
    chk("rst_no_ghost2", 32'(out_valid), 0);

    // randomized run against the queue model
    do_reset();
    exp_q.delete();
    model_err = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_ready = (exp_q.size() < 2);
      exp_valid = (exp_q.size() > 0);
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
      chk("rnd_out_valid", 32'(out_valid), 32'(exp_valid));
      chk("rnd_err", 32'(err_sticky), 32'(model_err));
      if (exp_valid) chk("rnd_word", 32'(dut_word()), 32'(exp_q[0]));
      iv  = ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 2) != 0);
      av  = int'($urandom_range(0, 15));
      sv  = int'($urandom_range(0, 15));
      yv  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15)) : model_shifted(av, sv);
      drive(iv, av, sv, yv);
      out_ready = orr;
      @(posedge clk);
      if (exp_valid && orr) void'(exp_q.pop_front());
      if (iv && exp_ready) begin
        exp_q.push_back(model_word(av, sv, yv));
        if (yv != model_shifted(av, sv)) model_err = 1'b1;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
